// File: rtl/lif_neuron_multichan_system.sv
// lif_neuron_multichan_system
// ---------------------------------------------------------------------------
// Multi-channel leaky integrate-and-fire neuron. Each unsigned input channel is
// scaled by its own signed weight. The weighted sum goes into a V_W-bit
// membrane. The leak is dual: leak_fast applies when v >= threshold/2, and
// leak_slow applies otherwise. The neuron also has a programmable refractory
// period. All parameters arrive as one serial frame, MSB-first. The frame is
// collected in a shadow register and copied to the active set only when the
// whole frame has been captured.
//
// Frame layout, starting from the first bit shifted in:
//   weight[0] .. weight[N_CHAN-1], threshold, leak_fast, leak_slow, refrac
//
// Optional build macro:
//   LIF_SPIKE_COUNT_EN  adds a saturating 8-bit spike counter on spike_count.
//                       When the macro is not defined, spike_count is tied to 0.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        global enable; when 0, all state holds and spike_out is 0
//   input_enable  1 = channel inputs contribute; 0 = leak-only update
//   chan_in       channel i at bits [i*IN_W +: IN_W], unsigned
//   load_mode     1 = capture serial configuration bits
//   serial_data   serial configuration bit
//   spike_out     one-cycle spike pulse
//   v_mem_out     registered membrane potential
//   params_ready  a complete frame has been committed to the active set
//   spike_count   saturating spike count (optional)
// ---------------------------------------------------------------------------
module lif_neuron_multichan_system #(
  parameter int N_CHAN   = 2,
  parameter int IN_W     = 6,
  parameter int W_W      = 4,
  parameter int V_W      = 8,
  parameter int LEAK_W   = 4,
  parameter int REFRAC_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     input_enable,
  input  logic [N_CHAN*IN_W-1:0]   chan_in,
  input  logic                     load_mode,
  input  logic                     serial_data,
  output logic                     spike_out,
  output logic [V_W-1:0]           v_mem_out,
  output logic                     params_ready,
  output logic [7:0]               spike_count
);

  localparam int FRAME_LEN = N_CHAN*W_W + V_W + 2*LEAK_W + REFRAC_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int FULL_W    = IN_W + W_W + $clog2(N_CHAN) + 2;

  // The last field shifted in ends up in the LSBs.
  localparam int OFF_RF  = 0;
  localparam int OFF_LS  = REFRAC_W;
  localparam int OFF_LF  = REFRAC_W + LEAK_W;
  localparam int OFF_THR = REFRAC_W + 2*LEAK_W;
  localparam int OFF_W   = OFF_THR + V_W;

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT_C  = CNT_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_INTEG   = 2'd2;
  localparam logic [1:0] ST_REFRACT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [V_W-1:0]       v_q, v_d;
  logic                 spike_q, spike_d;
  logic                 ready_q, ready_d;
  logic [FRAME_LEN-1:0] shadow_q, shadow_d;
  logic [FRAME_LEN-1:0] active_q, active_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [REFRAC_W-1:0]  rcnt_q, rcnt_d;
  logic                 load_q, load_d;

  logic                 load_rise;
  logic [CNT_W-1:0]     cnt_eff;
  logic [V_W-1:0]       thr;
  logic [LEAK_W-1:0]    leak_fast, leak_slow, leak_sel;
  logic [REFRAC_W-1:0]  refrac;
  logic signed [FULL_W-1:0] prod [N_CHAN];
  logic signed [FULL_W-1:0] sum_all, v_ext, leak_ext, next_full;
  logic [V_W-1:0]       v_clamp;

  assign load_rise = load_mode & ~load_q;
  assign thr       = active_q[OFF_THR +: V_W];
  assign leak_fast = active_q[OFF_LF +: LEAK_W];
  assign leak_slow = active_q[OFF_LS +: LEAK_W];
  assign refrac    = active_q[OFF_RF +: REFRAC_W];

  // Per-channel product. The channel is zero-extended and the weight is
  // sign-extended, so the multiply is done as signed.
  generate
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
      logic [W_W-1:0] w;
      logic signed [FULL_W-1:0] chan_ext, w_ext;
      assign w        = active_q[OFF_W + (N_CHAN-1-gi)*W_W +: W_W];
      assign chan_ext = $signed({{(FULL_W-IN_W){1'b0}}, chan_in[gi*IN_W +: IN_W]});
      assign w_ext    = $signed({{(FULL_W-W_W){w[W_W-1]}}, w});
      assign prod[gi] = chan_ext * w_ext;
    end
  endgenerate

  always_comb begin
    sum_all = '0;
    for (int i = 0; i < N_CHAN; i++) sum_all = sum_all + prod[i];
  end

  // The leak is selected from the membrane value before this update.
  assign leak_sel  = (v_q >= (thr >> 1)) ? leak_fast : leak_slow;
  assign v_ext     = $signed({{(FULL_W-V_W){1'b0}}, v_q});
  assign leak_ext  = $signed({{(FULL_W-LEAK_W){1'b0}}, leak_sel});
  assign next_full = v_ext + (input_enable ? sum_all : '0) - leak_ext;

  always_comb begin
    if (next_full[FULL_W-1])              v_clamp = '0;
    else if (|next_full[FULL_W-2:V_W])    v_clamp = '1;
    else                                  v_clamp = next_full[V_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    spike_d   = 1'b0;
    ready_d   = ready_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    bit_cnt_d = bit_cnt_q;
    rcnt_d    = rcnt_q;
    load_d    = load_q;
    cnt_eff   = bit_cnt_q;

    if (enable) begin
      load_d = load_mode;
      if (load_rise) ready_d = 1'b0;

      // A rising edge of load_mode restarts the frame. The bit seen on that
      // same cycle is the first bit of the new frame.
      if (load_mode) begin
        cnt_eff = load_rise ? '0 : bit_cnt_q;
        bit_cnt_d = cnt_eff;
        if (cnt_eff < FRAME_LEN_C) begin
          shadow_d  = {shadow_q[FRAME_LEN-2:0], serial_data};
          bit_cnt_d = cnt_eff + CNT_W'(1);
          if (cnt_eff == LAST_BIT_C) begin
            active_d = shadow_d;
            ready_d  = 1'b1;
          end
        end
      end

      if (load_rise) begin
        state_d = ST_LOAD;
      end else begin
        case (state_q)
          ST_IDLE: if (ready_q && !load_mode) state_d = ST_INTEG;
          ST_LOAD: if (!load_mode) state_d = ready_q ? ST_INTEG : ST_IDLE;
          ST_INTEG: begin
            if (v_clamp >= thr) begin
              spike_d = 1'b1;
              v_d     = '0;
              if (refrac != '0) begin
                state_d = ST_REFRACT;
                rcnt_d  = refrac;
              end
            end else begin
              v_d = v_clamp;
            end
          end
          default: begin
            v_d = '0;
            if (rcnt_q <= REFRAC_W'(1)) state_d = ST_INTEG;
            else                        rcnt_d  = rcnt_q - REFRAC_W'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      v_q       <= '0;
      spike_q   <= 1'b0;
      ready_q   <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      bit_cnt_q <= '0;
      rcnt_q    <= '0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      spike_q   <= spike_d;
      ready_q   <= ready_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      bit_cnt_q <= bit_cnt_d;
      rcnt_q    <= rcnt_d;
      load_q    <= load_d;
    end
  end

  assign spike_out    = spike_q;
  assign v_mem_out    = v_q;
  assign params_ready = ready_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] scnt_q, scnt_d;

  always_comb begin
    scnt_d = scnt_q;
    if (enable) begin
      if (load_rise)                     scnt_d = '0;
      else if (spike_d && scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) scnt_q <= '0;
    else       scnt_q <= scnt_d;
  end

  assign spike_count = scnt_q;
`else
  assign spike_count = '0;
`endif

endmodule

// File: tb/tb_lif_neuron_multichan_system.sv
// Directed testbench for lif_neuron_multichan_system with the default parameters.
module tb_lif_neuron_multichan_system;

  logic        clk = 1'b0;
  logic        reset, enable, input_enable, load_mode, serial_data;
  logic [11:0] chan_in;
  logic        spike_out, params_ready;
  logic [7:0]  v_mem_out, spike_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lif_neuron_multichan_system dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .input_enable (input_enable),
    .chan_in      (chan_in),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .spike_out    (spike_out),
    .v_mem_out    (v_mem_out),
    .params_ready (params_ready),
    .spike_count  (spike_count)
  );

  typedef struct {
    logic [5:0] c0;
    logic [5:0] c1;
    logic       ie;
    logic [7:0] v;
    logic       s;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift nbits of the frame MSB-first, then `extra` ones bits. Then drop
  // load_mode for one cycle. The membrane must hold hold_v throughout.
  task automatic load_frame(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [7:0] thr, input logic [3:0] lf,
                            input logic [3:0] ls, input logic [2:0] rf,
                            input int nbits, input int extra, input logic [7:0] hold_v);
    logic [26:0] frame;
    frame = {w0, w1, thr, lf, ls, rf};
    load_mode = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      serial_data = frame[26-i];
      step();
      check("load_hold_v", v_mem_out, hold_v);
      check("load_spike", spike_out, 0);
      if (i == 0) check("load_ready_clr", params_ready, 0);
    end
    for (int i = 0; i < extra; i++) begin
      serial_data = 1'b1;
      step();
    end
    check("load_ready", params_ready, (nbits == 27) ? 1 : 0);
    load_mode   = 1'b0;
    serial_data = 1'b0;
    step();
    check("load_exit_v", v_mem_out, hold_v);
  endtask

  task automatic drive(input logic [5:0] c0, input logic [5:0] c1, input logic ie);
    chan_in      = {c1, c0};
    input_enable = ie;
  endtask

  initial begin
    // Vectors for the frame w0=+3, w1=-2, thr=20, lf=2, ls=1, refrac=2.
    vecs[0]  = '{6'd4, 6'd0, 1'b1, 8'd11, 1'b0};
    vecs[1]  = '{6'd4, 6'd0, 1'b1, 8'd0,  1'b1};  // 11+12-2=21 >= 20
    vecs[2]  = '{6'd4, 6'd0, 1'b1, 8'd0,  1'b0};  // refractory
    vecs[3]  = '{6'd4, 6'd0, 1'b1, 8'd0,  1'b0};  // refractory
    vecs[4]  = '{6'd4, 6'd0, 1'b1, 8'd11, 1'b0};
    vecs[5]  = '{6'd0, 6'd0, 1'b1, 8'd9,  1'b0};  // fast leak
    vecs[6]  = '{6'd4, 6'd0, 1'b0, 8'd8,  1'b0};  // inputs gated, slow leak
    vecs[7]  = '{6'd0, 6'd3, 1'b1, 8'd1,  1'b0};  // 8-6-1
    vecs[8]  = '{6'd0, 6'd3, 1'b1, 8'd0,  1'b0};  // clamps at 0
    vecs[9]  = '{6'd2, 6'd1, 1'b1, 8'd3,  1'b0};
    vecs[10] = '{6'd6, 6'd0, 1'b1, 8'd0,  1'b1};  // exactly 20
    vecs[11] = '{6'd0, 6'd0, 1'b1, 8'd0,  1'b0};
    vecs[12] = '{6'd0, 6'd0, 1'b1, 8'd0,  1'b0};
    vecs[13] = '{6'd0, 6'd0, 1'b0, 8'd0,  1'b0};  // 0-1 clamps
    vecs[14] = '{6'd5, 6'd1, 1'b1, 8'd12, 1'b0};
    vecs[15] = '{6'd0, 6'd0, 1'b1, 8'd10, 1'b0};
    vecs[16] = '{6'd0, 6'd0, 1'b1, 8'd8,  1'b0};  // v == thr/2 uses fast leak

    reset = 1'b1; enable = 1'b1; input_enable = 1'b0; load_mode = 1'b0;
    serial_data = 1'b0; chan_in = '0;
    step(); step();
    check("rst_v", v_mem_out, 0);
    check("rst_spike", spike_out, 0);
    check("rst_ready", params_ready, 0);
    check("rst_count", spike_count, 0);
    reset = 1'b0;

    load_frame(4'b0011, 4'b1110, 8'd20, 4'd2, 4'd1, 3'd2, 27, 0, 8'd0);
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].c0, vecs[i].c1, vecs[i].ie);
      step();
      check($sformatf("vec%0d_v", i), v_mem_out, vecs[i].v);
      check($sformatf("vec%0d_spike", i), spike_out, vecs[i].s);
    end

    // The enable gate freezes the membrane.
    enable = 1'b0;
    drive(6'd63, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dis_v", v_mem_out, 8);
      check("dis_spike", spike_out, 0);
    end
    enable = 1'b1;

    // Reload in mid-operation, then test positive saturation with refrac=0.
    load_frame(4'b0111, 4'b0000, 8'd255, 4'd0, 4'd0, 3'd0, 27, 0, 8'd8);
    drive(6'd63, 6'd0, 1'b1);
    step();
    check("sat_v", v_mem_out, 0);
    check("sat_spike", spike_out, 1);
    drive(6'd0, 6'd0, 1'b1);
    step();
    check("sat_after_v", v_mem_out, 0);
    check("sat_after_spike", spike_out, 0);

    // Negative clamp.
    load_frame(4'b0001, 4'b1000, 8'd200, 4'd0, 4'd0, 3'd0, 27, 0, 8'd0);
    drive(6'd5, 6'd0, 1'b1);
    step();
    check("neg_pre_v", v_mem_out, 5);
    drive(6'd0, 6'd63, 1'b1);
    step();
    check("neg_v", v_mem_out, 0);
    check("neg_spike", spike_out, 0);

    // A partial frame leaves the neuron idle.
    drive(6'd7, 6'd0, 1'b1);
    step();
    check("part_pre_v", v_mem_out, 7);
    load_frame(4'b0010, 4'b0000, 8'd200, 4'd0, 4'd0, 3'd0, 26, 0, 8'd7);
    drive(6'd5, 6'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("idle_v", v_mem_out, 7);
      check("idle_ready", params_ready, 0);
    end
    // The bits after the 27th must be ignored.
    load_frame(4'b0001, 4'b0000, 8'd200, 4'd0, 4'd0, 3'd0, 27, 3, 8'd7);
    step();
    check("full_v1", v_mem_out, 12);
    step();
    check("full_v2", v_mem_out, 17);

    // With threshold 0, the neuron spikes on every cycle.
    load_frame(4'b0000, 4'b0000, 8'd0, 4'd0, 4'd0, 3'd0, 27, 0, 8'd17);
    for (int i = 0; i < 5; i++) begin
      step();
      check("thr0_spike", spike_out, 1);
      check("thr0_v", v_mem_out, 0);
    end
    for (int i = 0; i < 295; i++) step();
`ifdef LIF_SPIKE_COUNT_EN
    check("count_sat", spike_count, 255);
`else
    check("count_tied", spike_count, 0);
`endif
    reset = 1'b1;
    step();
    check("rst2_count", spike_count, 0);
    check("rst2_ready", params_ready, 0);
    check("rst2_spike", spike_out, 0);
    reset = 1'b0;

    // Reset during the refractory period.
    load_frame(4'b0000, 4'b0000, 8'd0, 4'd0, 4'd0, 3'd7, 27, 0, 8'd0);
    step();
    check("ref_spike", spike_out, 1);
    step();
    check("ref_quiet", spike_out, 0);
    reset = 1'b1;
    step();
    check("rst3_ready", params_ready, 0);
    check("rst3_v", v_mem_out, 0);
    reset = 1'b0;
    step();
    check("post_rst_spike", spike_out, 0);
    check("post_rst_ready", params_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
